pio_edge_irq_in: RTL
====================

PIO_EDGE_IRQ_IN -- requirements
Module: pio_edge_irq_in

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge that sets capture; 0 rising, 1 falling, 2 any.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flop depth, legal range 2..4.
REQ-004 Parameter FILT_W, default 8: width of the debounce counters and the debounce register.
REQ-005 Parameter FILT_DEF, default 0: reset value of the debounce register; 0 means no filtering.
REQ-006 clk  input  1: single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1: reset, synchronous and active-low.
REQ-008 address  input  2: register word select.
REQ-009 chipselect  input  1: slave select; qualifies writes only.
REQ-010 write_n  input  1: active-low write strobe.
REQ-011 writedata  input  32: write data.
REQ-012 in_port  input  WIDTH: asynchronous external inputs.
REQ-013 readdata  output  32: registered read data.
REQ-014 irq  output  1: level interrupt, high while any unmasked capture bit is set.

Function
REQ-015 Register map SHALL be: 0 DATA (RO, filtered level), 1 DEBOUNCE (RW, FILT_W bits), 2 IRQMASK (RW, WIDTH bits), 3 EDGECAP (write-1-to-clear).
REQ-016 Write strobe SHALL be chipselect && !write_n; writes to address 0 are ignored.
REQ-017 readdata SHALL load every cycle from the address-selected register (one-cycle read latency, independent of chipselect); bits above the register width read 0.
REQ-018 Each in_port bit SHALL pass through SYNC_STAGES flops (sync[i]) before any use.
REQ-019 Per bit, a FILT_W counter SHALL clear when sync equals filt, otherwise increment; when sync != filt and count >= DEBOUNCE, filt takes sync and the counter clears.
REQ-020 With DEBOUNCE = 0, filt SHALL follow sync with one cycle of delay; total in_port-to-filt latency is SYNC_STAGES+1 cycles.
REQ-021 The counter SHALL saturate at 2^FILT_W-1, never wrap.
REQ-022 A bit's edge event SHALL be the cycle filt updates, qualified by EDGE_TYPE (0: 0->1, 1: 1->0, 2: either).
REQ-023 An edge event SHALL set the EDGECAP bit on the same clock filt updates; the bit stays set until cleared.
REQ-024 Writing 1 to an EDGECAP bit SHALL clear it; writing 0 leaves it unchanged.
REQ-025 Simultaneous clear write and edge event on the same bit SHALL leave the bit set (the edge is not lost).
REQ-026 irq SHALL equal OR over bits of (EDGECAP & IRQMASK), combinational from registers, no extra delay.
REQ-027 A DEBOUNCE write SHALL take effect the next cycle; in-flight counters compare against the new value (>=), so lowering it may release a pending bit immediately.
REQ-028 IRQMASK changes SHALL affect irq only; capture continues for masked bits.

Reset
REQ-029 While reset_n is low at a clk edge: sync stages, filt, counters, EDGECAP, IRQMASK and readdata SHALL clear to 0, DEBOUNCE SHALL load FILT_DEF, irq SHALL be 0.
REQ-030 Reset mid-debounce SHALL discard the pending count; an input already high at reset release produces a rising edge event after the filter delay.
REQ-031 No state SHALL change asynchronously to clk.

Verification
REQ-032 WIDTH=8, DEBOUNCE=0, mask=0xFF: in_port 0x00->0x05 -> filt 0x05 after 3 cycles, EDGECAP=0x05, irq=1; read addr 0 returns 0x05 one cycle after address is applied.
REQ-033 DEBOUNCE=4: bit0 pulse of 3 cycles -> no filt change, EDGECAP=0; pulse of 8 cycles -> filt rises 5 cycles after sync, EDGECAP bit0 set.
REQ-034 EDGECAP=0x03, write 0x01 to addr 3 -> EDGECAP=0x02; same cycle as a new bit0 edge -> EDGECAP=0x03.
REQ-035 EDGE_TYPE=2, mask=0x00: bit3 toggles 1->0 -> EDGECAP=0x08, irq=0; write mask=0x08 -> irq=1 next cycle.
REQ-036 DEBOUNCE=200, bit1 held for 50 cycles, write DEBOUNCE=10 -> bit1 filt updates on the cycle after the write.
REQ-037 Assert reset_n low with pending count and EDGECAP=0xFF -> all registers 0, DEBOUNCE=FILT_DEF, irq=0 after one clk edge.

Source files
------------

// File: rtl/pio_edge_irq_in.sv
// ---------------------------------------------------------------------------
// pio_edge_irq_in -- parallel input port with synchroniser, per-bit debounce
// filter, edge capture and level interrupt.
//
// Ports
//   clk         single clock, all state on rising edge
//   reset_n     synchronous active-low reset
//   address     register word select
//                 0 DATA    (RO, filtered input level)
//                 1 DEBOUNCE(RW, FILT_W bits, cycles a change must persist)
//                 2 IRQMASK (RW, WIDTH bits)
//                 3 EDGECAP (write 1 to clear)
//   chipselect  slave select, qualifies writes only
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle after address
//   irq         high while any unmasked capture bit is set
// ---------------------------------------------------------------------------

// Per-bit lane: synchroniser, debounce counter, filtered level and the
// qualified edge event for this bit.
module pio_edge_irq_in_lane #(
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              din,
    input  logic [FILT_W-1:0] debounce,
    output logic              filt,
    output logic              edge_evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [FILT_W-1:0]      cnt;
    logic                   upd;

    assign sync = sync_q[SYNC_STAGES-1];

    // Compared against the live DEBOUNCE value, so lowering it releases a
    // bit whose count already exceeds the new threshold on the next edge.
    assign upd = (sync != filt) && (cnt >= debounce);

    // Edge is reported on the same cycle filt takes the new value; the new
    // value is sync, so its polarity tells rising from falling.
    assign edge_evt = upd && ((EDGE_TYPE == 0) ? sync  :
                              (EDGE_TYPE == 1) ? !sync : 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            filt   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            if (sync == filt) begin
                cnt <= '0;
            end else if (upd) begin
                filt <= sync;
                cnt  <= '0;
            end else if (cnt != '1) begin
                // saturate rather than wrap so a long-pending bit stays pending
                cnt <= cnt + FILT_W'(1);
            end
        end
    end

endmodule

module pio_edge_irq_in #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int FILT_DEF    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_DEB  = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_CAP  = 2'd3;

    logic              wr;
    logic [FILT_W-1:0] debounce;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  filt;
    logic [WIDTH-1:0]  edge_evt;
    logic [WIDTH-1:0]  cap_clr;
    logic              wdata_unused;

    assign wr = chipselect && !write_n;

    // Upper writedata bits are ignored when the registers are narrower.
    assign wdata_unused = &{1'b0, writedata};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            pio_edge_irq_in_lane #(
                .EDGE_TYPE  (EDGE_TYPE),
                .SYNC_STAGES(SYNC_STAGES),
                .FILT_W     (FILT_W)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .din     (in_port[gi]),
                .debounce(debounce),
                .filt    (filt[gi]),
                .edge_evt(edge_evt[gi])
            );
        end
    endgenerate

    assign cap_clr = (wr && address == A_CAP) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            debounce <= FILT_W'(FILT_DEF);
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr && address == A_DEB)
                debounce <= writedata[FILT_W-1:0];
            if (wr && address == A_MASK)
                irq_mask <= writedata[WIDTH-1:0];
            // Set wins over clear so an edge coinciding with a clear survives.
            edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
        end
    end

    // Read path loads every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                A_DATA:  readdata <= 32'(filt);
                A_DEB:   readdata <= 32'(debounce);
                A_MASK:  readdata <= 32'(irq_mask);
                default: readdata <= 32'(edge_cap);
            endcase
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule
